// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard control: stall/flush generation, prioritised PC redirect arbitration, event counters, stall watchdog.
// Latency: stall/flush/redirect/pc outputs are combinational (zero cycles); cnt_data and deadlock are registered (one cycle).
// Backpressure: a redirect source is acked only when its stage advances; an unacked source must hold its request valid.
module pipeline_hazard_unit #(
    parameter int                          NUM_STAGES     = 5,
    parameter int                          NUM_REDIRECT   = 2,
    parameter logic [8*NUM_REDIRECT-1:0]   REDIRECT_STAGE = {8'd2, 8'd1},
    parameter logic [NUM_REDIRECT-1:0]     REDIRECT_KILL  = 2'b10,
    parameter int                          ADDR_WIDTH     = 32,
    parameter int                          CNT_WIDTH      = 32,
    parameter int                          TIMEOUT        = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_STAGES-1:0]             hold_req,
    input  logic [NUM_REDIRECT-1:0]           redirect_valid,
    input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_target,
    output logic [NUM_REDIRECT-1:0]           redirect_ack,
    output logic [NUM_STAGES-1:0]             stall,
    output logic [NUM_STAGES-1:0]             flush,
    output logic                              pc_we,
    output logic [ADDR_WIDTH-1:0]             pc_new,
    input  logic                              cnt_clear,
    input  logic [7:0]                        cnt_sel,
    output logic [CNT_WIDTH-1:0]              cnt_data,
    output logic                              deadlock
);

    localparam int NUM_CNT = 2*NUM_STAGES + NUM_REDIRECT + 1;
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    logic [NUM_STAGES-1:0]   base_stall;
    logic [NUM_STAGES-1:0]   base_flush;
    logic [NUM_REDIRECT-1:0] elig;
    logic [NUM_CNT-1:0]      ev;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_data_q, cnt_data_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 deadlock_q, deadlock_d;

    // Base hazards: a hold anywhere downstream freezes every register upstream of it,
    // and the first register that still moves behind a frozen one takes a bubble.
    always_comb begin
        base_stall = '0;
        base_flush = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            base_stall[k] = |(hold_req >> k);
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            base_flush[k] = base_stall[k-1] & ~base_stall[k];
        end
        for (int j = 0; j < NUM_REDIRECT; j++) begin
            elig[j] = redirect_valid[j] & ~base_stall[int'(REDIRECT_STAGE[8*j +: 8])];
        end
    end

    // Redirect arbitration and final stall/flush/PC controls; a killing winner squashes
    // everything younger than its stage, overriding front-end holds such as an I-cache miss.
    always_comb begin
        int win;
        int s;
        win          = -1;
        s            = 0;
        stall        = base_stall;
        flush        = base_flush;
        redirect_ack = '0;
        pc_we        = 1'b0;
        pc_new       = redirect_target[0 +: ADDR_WIDTH];
        for (int j = 0; j < NUM_REDIRECT; j++) begin
            if (elig[j]) begin
                win = j;
            end
        end
        if (win >= 0) begin
            s                 = int'(REDIRECT_STAGE[8*win +: 8]);
            redirect_ack[win] = 1'b1;
            pc_we             = 1'b1;
            pc_new            = redirect_target[ADDR_WIDTH*win +: ADDR_WIDTH];
            if (REDIRECT_KILL[win]) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (k >= 1 && k <= s) flush[k] = 1'b1;
                    if (k < s)            stall[k] = 1'b0;
                end
            end
        end
        if (rst) begin
            stall        = '0;
            flush        = {{(NUM_STAGES-1){1'b1}}, 1'b0};
            redirect_ack = '0;
            pc_we        = 1'b0;
            pc_new       = '0;
        end
    end

    // Event vector in counter-index order, plus saturating counter / readout / watchdog next state.
    always_comb begin
        logic [CNT_WIDTH-1:0] rd;
        ev = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            ev[k]              = stall[k];
            ev[NUM_STAGES + k] = flush[k];
        end
        for (int j = 0; j < NUM_REDIRECT; j++) begin
            ev[2*NUM_STAGES + j] = redirect_ack[j];
        end
        ev[2*NUM_STAGES + NUM_REDIRECT] = |(redirect_valid & ~redirect_ack);

        rd = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_clear) begin
                cnt_d[i] = '0;
            end else if (ev[i] && !(&cnt_q[i])) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (cnt_sel == 8'(i)) rd = cnt_q[i];
        end
        cnt_data_d = cnt_clear ? '0 : rd;

        if (!stall[0]) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        deadlock_d = deadlock_q | (wd_d == WD_W'(TIMEOUT));
        if (cnt_clear) begin
            wd_d       = '0;
            deadlock_d = 1'b0;
        end
    end

    // State registers for counters, readout, watchdog and the sticky deadlock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
            cnt_data_q <= '0;
            wd_q       <= '0;
            deadlock_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
            cnt_data_q <= cnt_data_d;
            wd_q       <= wd_d;
            deadlock_q <= deadlock_d;
        end
    end

    assign cnt_data = cnt_data_q;
    assign deadlock = deadlock_q;

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the fixed 5-stage hazard controller.
- Generalises stall/flush generation to NUM_STAGES pipeline registers and arbitrates NUM_REDIRECT prioritised PC redirect sources with a ready/ack handshake.
- Replaces simulation-only stats with synthesizable saturating per-event counters and adds a stall watchdog.
- Sits beside the pipeline registers; drives their stall/flush controls and the PC load port.

Parameters:
- NUM_STAGES, 5, pipeline registers; reg 0 = PC, reg k = input register of stage k (2..16).
- NUM_REDIRECT, 2, redirect sources; higher index = older stage = higher priority.
- REDIRECT_STAGE, {8'd2,8'd1}, packed 8 bits per source: originating stage s_j. Strictly ascending with j; 1 <= s_j < NUM_STAGES.
- REDIRECT_KILL, 2'b10, bit j=1: source j squashes younger instructions. Only bit 0 may be 0 (delay-slot semantics).
- ADDR_WIDTH, 32, PC width.
- CNT_WIDTH, 32, event counter width.
- TIMEOUT, 1024, consecutive stall[0] cycles before deadlock asserts.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-high reset.
- hold_req in NUM_STAGES: stage k cannot complete this cycle (cache miss, lw hazard, ...).
- redirect_valid in NUM_REDIRECT: source j requests a PC load.
- redirect_target in NUM_REDIRECT*ADDR_WIDTH: target for source j.
- redirect_ack out NUM_REDIRECT: source j accepted this cycle.
- stall out NUM_STAGES: register k holds its value.
- flush out NUM_STAGES: register k loads a bubble (bit 0 is always 0).
- pc_we out 1: load PC.
- pc_new out ADDR_WIDTH: PC value to load.
- cnt_clear in 1: synchronous clear of all counters and deadlock.
- cnt_sel in 8: counter index to read.
- cnt_data out CNT_WIDTH: selected counter value, registered.
- deadlock out 1: sticky watchdog flag.

Behaviour:
- Base stall: stall[k] = OR(hold_req[k..NUM_STAGES-1]); downstream holds propagate upstream.
- Base flush: flush[k] = stall[k-1] & ~stall[k] for k >= 1, inserting a bubble behind a holding stage.
- Eligibility: source j is eligible when redirect_valid[j] and hold_req[s_j..NUM_STAGES-1] == 0, i.e. stage s_j advances. Ineligible sources get ack=0 and must hold valid.
- Winner: the highest-index eligible source. Only the winner is acked.
  - pc_we=1, pc_new=winner target.
  - If REDIRECT_KILL[j]: flush[1..s_j]=1 and stall[0..s_j-1]=0. This overrides younger holds, e.g. an I-cache miss; the cache does not register missed requests.
  - Lower-index valid sources sit in killed stages and are dropped (ack=0).
- Non-kill source 0 winning: pc_we only; stall/flush unchanged. A PC write coinciding with stall[0] still takes effect.
- No winner: pc_we=0, pc_new=target of source 0 (don't-care).
- All the above is combinational, zero latency.
- Counters: CNT_WIDTH saturating at all-ones, one update per cycle.
  - Index k: cycles stall[k]=1.
  - Index NUM_STAGES+k: cycles flush[k]=1.
  - Index 2*NUM_STAGES+j: redirect_ack[j] count.
  - Index 2*NUM_STAGES+NUM_REDIRECT: cycles with any valid but unacked redirect.
  - Other indices read 0.
- cnt_data = counter[cnt_sel] one cycle after cnt_sel. Same-cycle update plus read returns the pre-update value.
- cnt_clear: all counters, cnt_data and the watchdog go to 0 next edge. If an event coincides with cnt_clear, the clear wins (counter = 0, not 1).
- Watchdog: counts consecutive stall[0] cycles and resets to 0 on any cycle with stall[0]=0. Reaching TIMEOUT sets deadlock; deadlock stays set until rst or cnt_clear. The watchdog counter saturates at TIMEOUT.
- Reset (async, any cycle): counters=0, cnt_data=0, deadlock=0, watchdog=0. While rst=1: stall=0, flush=all-ones except bit 0, pc_we=0, redirect_ack=0, pc_new=0.

Test Plan:
- N=5: hold_req=5'b00100 -> stall=5'b00111, flush=5'b01000, pc_we=0. After 3 cycles, counter 2 reads 3.
- redirect_valid=2'b11, targets 0x100/0x200, no holds -> ack=2'b10, pc_new=0x200, flush=5'b00110, stall=0.
- hold_req[0]=1 (I-miss) plus source 1 valid -> ack[1]=1, stall[0]=0, flush[1]=1. Source 1 with hold_req[4]=1 -> ack=0, stall=5'b11111, pc_we=0 until the hold drops.
- Source 0 alone (non-kill) -> ack=2'b01, pc_we=1, pc_new=0x100, flush=0, stall=0.
- TIMEOUT=8, hold_req[0] for 8 cycles -> deadlock=1 at the 8th edge and stays set after the hold drops. cnt_clear -> deadlock=0 next cycle.
- Force counter 0 near all-ones -> it saturates. Assert rst mid-stall -> outputs take reset values immediately (asynchronously), counters read 0 after release.
